dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Shares the pipelined core's single-port data memory between two requesters: the core load/store path (port C) and a debug/DMA master (port D).
- Sits between the datapath's data-memory interface and the physical synchronous RAM.
- Issues one command per grant and tracks the read latency.
- Returns read data to the owning requester.
- Generates a stall for the core pipeline while the core's access is pending.

Parameters:
- WIDTH, `WIDTH: data width.
- ADD_W, `D_ADD_SIZE: data address width.
- RD_LAT, 1: memory read latency in cycles, from command to valid i_m_rdata. Legal range 1..7.

Ports:
- i_clk  in  1  clock.
- i_rstn  in  1  synchronous active-low reset.
- i_c_req  in  1  core access request.
- i_c_we  in  1  core write enable (1 = store).
- i_c_add  in  ADD_W  core address.
- i_c_wdata  in  WIDTH  core store data.
- o_c_gnt  out  1  core command accepted this cycle.
- o_c_rvalid  out  1  core read data valid.
- o_c_rdata  out  WIDTH  core read data.
- o_c_stall  out  1  freeze the core pipeline.
- i_d_req, i_d_we, i_d_add, i_d_wdata  in  1/1/ADD_W/WIDTH  debug port request, write enable, address and data.
- o_d_gnt, o_d_rvalid, o_d_rdata  out  1/1/WIDTH  debug port grant, read valid and read data.
- o_m_en  out  1  memory command strobe.
- o_m_we  out  1  memory write.
- o_m_add  out  ADD_W  memory address.
- o_m_wdata  out  WIDTH  memory write data.
- i_m_rdata  in  WIDTH  memory read data.

Behaviour:
- Clocking and reset:
  - Single clock.
  - Reset is synchronous, active-low, sampled on the i_clk rising edge.
  - During reset: state = IDLE, latency counter = 0, owner = C, RR pointer = C.
  - All outputs are 0 during reset: gnt, rvalid, rdata, m_en, m_we, stall.
- FSM states:
  - IDLE: no read outstanding.
  - RD_WAIT: read outstanding, with an owner register and a counter.
- Grant rules (combinational, same cycle as the request):
  - A grant is issued only in IDLE, or in the RD_WAIT cycle where rvalid is asserted (back-to-back).
  - At most one gnt per cycle.
  - A requester must hold req, we, add and wdata stable until it sees gnt.
- Grant cycle:
  - o_m_en = 1.
  - o_m_we, o_m_add and o_m_wdata are driven from the winning port.
  - Outside a grant cycle, o_m_en = o_m_we = 0, and add/wdata hold the last value.
- Writes:
  - Complete in the grant cycle; no response is generated.
  - The FSM stays in IDLE.
- Reads:
  - Grant at cycle N moves the FSM to RD_WAIT, loads counter = RD_LAT, latches the owner.
  - The counter decrements each cycle.
  - When counter == 1 (cycle N+RD_LAT), the owner's rvalid = 1 and its rdata = i_m_rdata. rdata is registered and held until the next rvalid.
  - The next cycle returns to IDLE unless a new read was granted in the same cycle.
- Throughput:
  - One read per RD_LAT cycles.
  - One write per cycle.
- Priority (default): fixed, C > D.
- o_c_stall = (i_c_req & ~o_c_gnt) | (read outstanding with owner C & ~o_c_rvalid).
- Boundary cases:
  - Simultaneous requests in IDLE: the winner is chosen by the priority rule.
  - The loser keeps req high and waits; it receives no gnt.
  - Request arriving during RD_WAIT: gnt = 0 until the rvalid cycle.
  - Reset in RD_WAIT: the read is abandoned and no rvalid is produced afterwards.
  - A write granted in the rvalid cycle is legal (memory command concurrent with returning data).

Optional Feature:
- DMEM_ARB_RR_EN defined: round-robin arbitration.
  - The pointer records the last granted port and updates on every gnt.
  - On contention, the port that was not last granted wins.
  - Guarantees D is granted within 2 grants of asserting req.
- Undefined: fixed priority C > D; the pointer logic is absent.

Decomposition:
- Shared package/header (parameters.vh extension):
  - FSM state encodings: ARB_IDLE, ARB_RD_WAIT.
  - Owner IDs: OWN_C = 1'b0, OWN_D = 1'b1.
  - RD_LAT counter width: 3 bits.
- One sub-module, dmem_rd_tracker:
  - Contains the latency counter, owner register and rvalid/rdata registers.
  - Inputs: issue, owner, i_m_rdata.
  - Outputs: busy, done, owner.
- The top level holds the arbitration logic and muxes.

Test Plan:
- Core write: C write add=0x10 wdata=0xDEADBEEF -> gnt_c same cycle; m_en=1, m_we=1, m_add=0x10; stall=0; FSM stays IDLE.
- Core read, RD_LAT=2: C read at cycle 5 -> gnt_c at 5; c_rvalid at 7 with rdata = memory word; stall=1 at cycles 5–6, 0 at 7.
- Contention, fixed priority: C and D both read, RD_LAT=1 -> C granted at cycle 0, D granted at cycle 1 (back-to-back), d_rvalid at 2.
- Contention with DMEM_ARB_RR_EN: C and D both hold req for 4 reads -> grants alternate C, D, C, D.
- Reset during RD_WAIT (RD_LAT=3): i_rstn=0 one cycle after grant -> no rvalid ever; all outputs 0; a new C read after reset is granted normally.
- Busy blocking: D read in flight (RD_LAT=3) and C write arriving at N+1 -> gnt_c=0 at N+1 and N+2, gnt_c=1 at N+3; stall high at N+1..N+2.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared constants for the data-memory arbiter: FSM state codes, owner IDs and
// latency counter sizing.
package dmem_arbiter_pkg;

  // Width of the read-latency counter; supports RD_LAT of 1..7.
  localparam int unsigned CNT_W = 3;

  // Read-tracker FSM states.
  localparam logic [0:0] ARB_IDLE    = 1'b0;
  localparam logic [0:0] ARB_RD_WAIT = 1'b1;

  // Requester identities, also used for the round-robin pointer.
  localparam logic OWN_C = 1'b0;
  localparam logic OWN_D = 1'b1;

  // Counter load value for a given read latency.
  function automatic logic [CNT_W-1:0] lat_load(input int unsigned lat);
    return CNT_W'(lat);
  endfunction

endpackage

// File: rtl/dmem_rd_tracker.sv
// Tracks one outstanding read: latency counter, owner, and per-port held
// read data. done marks the cycle the memory presents the read word.
module dmem_rd_tracker
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_issue,
  input  logic             i_owner,
  input  logic [WIDTH-1:0] i_m_rdata,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_owner,
  output logic [WIDTH-1:0] o_c_rdata,
  output logic [WIDTH-1:0] o_d_rdata
);

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             owner_q, owner_d;
  logic [WIDTH-1:0] c_rdata_q, c_rdata_d;
  logic [WIDTH-1:0] d_rdata_q, d_rdata_d;

  assign o_busy  = (state_q == ARB_RD_WAIT);
  assign o_done  = o_busy && (cnt_q == CNT_W'(1));
  assign o_owner = owner_q;

  // Return data bypasses straight from memory in the done cycle, then is held.
  assign o_c_rdata = (o_done && owner_q == OWN_C) ? i_m_rdata : c_rdata_q;
  assign o_d_rdata = (o_done && owner_q == OWN_D) ? i_m_rdata : d_rdata_q;

  // Next-state: count down, capture data on done, reload on a new issue.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    owner_d   = owner_q;
    c_rdata_d = c_rdata_q;
    d_rdata_d = d_rdata_q;
    if (o_busy) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    if (o_done) begin
      state_d = ARB_IDLE;
      if (owner_q == OWN_C) c_rdata_d = i_m_rdata;
      else                  d_rdata_d = i_m_rdata;
    end
    // A back-to-back issue in the done cycle overrides the return to idle.
    if (i_issue) begin
      state_d = ARB_RD_WAIT;
      cnt_d   = lat_load(RD_LAT);
      owner_d = i_owner;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q   <= ARB_IDLE;
      cnt_q     <= '0;
      owner_q   <= OWN_C;
      c_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      owner_q   <= owner_d;
      c_rdata_q <= c_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the core load/store port (C) and a debug/DMA
// port (D). Fixed priority C > D by default; define DMEM_ARB_RR_EN for
// round-robin arbitration between the two ports.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ADD_W  = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_c_req,
  input  logic             i_c_we,
  input  logic [ADD_W-1:0] i_c_add,
  input  logic [WIDTH-1:0] i_c_wdata,
  output logic             o_c_gnt,
  output logic             o_c_rvalid,
  output logic [WIDTH-1:0] o_c_rdata,
  output logic             o_c_stall,
  input  logic             i_d_req,
  input  logic             i_d_we,
  input  logic [ADD_W-1:0] i_d_add,
  input  logic [WIDTH-1:0] i_d_wdata,
  output logic             o_d_gnt,
  output logic             o_d_rvalid,
  output logic [WIDTH-1:0] o_d_rdata,
  output logic             o_m_en,
  output logic             o_m_we,
  output logic [ADD_W-1:0] o_m_add,
  output logic [WIDTH-1:0] o_m_wdata,
  input  logic [WIDTH-1:0] i_m_rdata
);

  logic             busy, done, trk_owner;
  logic [WIDTH-1:0] c_rdata_h, d_rdata_h;
  logic             can_grant, d_pick, c_gnt, d_gnt, gnt_any, sel_we, issue;
  logic [ADD_W-1:0] sel_add, add_q, add_d;
  logic [WIDTH-1:0] sel_wdata, wdata_q, wdata_d;
  logic             c_rvalid;

`ifdef DMEM_ARB_RR_EN
  logic ptr_q, ptr_d;
`endif

  // Arbitration: grant only when no read is pending or one completes now.
  always_comb begin
    can_grant = ~busy | done;
`ifdef DMEM_ARB_RR_EN
    // On contention the port that was not granted last wins.
    d_pick = i_d_req & (~i_c_req | (ptr_q == OWN_C));
`else
    d_pick = i_d_req & ~i_c_req;
`endif
    c_gnt     = i_rstn & can_grant & i_c_req & ~d_pick;
    d_gnt     = i_rstn & can_grant & d_pick;
    gnt_any   = c_gnt | d_gnt;
    sel_we    = d_pick ? i_d_we    : i_c_we;
    sel_add   = d_pick ? i_d_add   : i_c_add;
    sel_wdata = d_pick ? i_d_wdata : i_c_wdata;
    issue     = gnt_any & ~sel_we;
  end

  // Remember the last command address/data so the bus holds between grants.
  always_comb begin
    add_d   = add_q;
    wdata_d = wdata_q;
    if (gnt_any) begin
      add_d   = sel_add;
      wdata_d = sel_wdata;
    end
  end

  // Address/data hold registers.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      add_q   <= '0;
      wdata_q <= '0;
    end else begin
      add_q   <= add_d;
      wdata_q <= wdata_d;
    end
  end

`ifdef DMEM_ARB_RR_EN
  // Round-robin pointer follows every grant.
  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any) ptr_d = d_gnt ? OWN_D : OWN_C;
  end

  // Pointer register.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) ptr_q <= OWN_C;
    else         ptr_q <= ptr_d;
  end
`endif

  dmem_rd_tracker #(
    .WIDTH  (WIDTH),
    .RD_LAT (RD_LAT)
  ) u_rd_tracker (
    .i_clk     (i_clk),
    .i_rstn    (i_rstn),
    .i_issue   (issue),
    .i_owner   (d_gnt ? OWN_D : OWN_C),
    .i_m_rdata (i_m_rdata),
    .o_busy    (busy),
    .o_done    (done),
    .o_owner   (trk_owner),
    .o_c_rdata (c_rdata_h),
    .o_d_rdata (d_rdata_h)
  );

  assign c_rvalid   = i_rstn & done & (trk_owner == OWN_C);
  assign o_c_rvalid = c_rvalid;
  assign o_d_rvalid = i_rstn & done & (trk_owner == OWN_D);
  assign o_c_rdata  = i_rstn ? c_rdata_h : '0;
  assign o_d_rdata  = i_rstn ? d_rdata_h : '0;
  assign o_c_gnt    = c_gnt;
  assign o_d_gnt    = d_gnt;

  assign o_m_en    = gnt_any;
  assign o_m_we    = gnt_any & sel_we;
  assign o_m_add   = gnt_any ? sel_add   : add_q;
  assign o_m_wdata = gnt_any ? sel_wdata : wdata_q;

  // Stall while C waits for a grant, or from its read grant until data returns.
  assign o_c_stall = i_rstn & ((i_c_req & ~c_gnt) | (c_gnt & ~i_c_we) |
                               (busy & (trk_owner == OWN_C) & ~c_rvalid));

endmodule
